key: RTL and testbench
======================

KEY -- requirements
Module: key

Interface
REQ-001 Parameter CNT_MAX, default 20'd1_000_000, is the debounce window in clock cycles (20 ms at 50 MHz); legal range is 2 to 2^20-1.
REQ-002 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1 bit: synchronous, active-high reset (rst_n=1 at a rising edge resets); the name is kept per codebase convention.
REQ-004 Port key1, input, 1 bit: raw mechanical push-button, asynchronous, active-low (idle 1, pressed 0), may bounce.
REQ-005 Port led0, output, 1 bit: registered LED drive; 1 = on; toggles once per debounced press.

Function
REQ-006 key1 SHALL pass through a 2-flop synchronizer (s1, then s2) before any other use; only s2 feeds the debounce logic.
REQ-007 A debounced state register "stable" SHALL hold the accepted key level; reset value is 1 (released).
REQ-008 Counter cnt SHALL be 20 bits wide, reset value 0.
REQ-009 At each edge where s2 equals stable, cnt SHALL clear to 0 (any bounce restarts the window).
REQ-010 At each edge where s2 differs from stable and cnt < CNT_MAX-1, cnt SHALL increment by 1.
REQ-011 At an edge where s2 differs from stable and cnt = CNT_MAX-1, stable SHALL take s2 and cnt SHALL clear to 0.
REQ-012 The counter SHALL never wrap; its maximum value is CNT_MAX-1.
REQ-013 A press event is defined as stable changing 1->0; led0 SHALL invert on the same clock edge that stable commits 1->0.
REQ-014 A release (stable 0->1) SHALL NOT change led0.
REQ-015 Holding the key indefinitely SHALL produce exactly one toggle; there is no auto-repeat.
REQ-016 Latency: if key1 falls cleanly and stays low, led0 SHALL change at rising edge CNT_MAX+1, where edge 0 is the first edge that samples key1 low.
REQ-017 A low pulse shorter than CNT_MAX consecutive synchronized cycles SHALL produce no toggle.
REQ-018 Release debouncing SHALL be symmetric: stable returns to 1 only after CNT_MAX consecutive synchronized-high cycles.

Reset
REQ-019 While rst_n=1 at an edge: s1=1, s2=1, stable=1, cnt=0, led0=0, regardless of key1.
REQ-020 Reset has priority over all other updates; reset mid-count SHALL discard partial counts.
REQ-021 After reset deassertion, a key1 held low SHALL be treated as a fresh press (per REQ-016, counting from the first post-reset edge).

Structure
REQ-022 A shared package key_pkg SHALL hold the CNT_MAX default constant and the counter width (20).
REQ-023 Debounce logic (REQ-006 to REQ-012, REQ-018) SHALL be one sub-module, key_debounce, outputting stable and a 1-cycle press pulse; the top level holds the led0 toggle register.

Verification (CNT_MAX=10, clk period 20 ns)
REQ-024 Reset: hold rst_n=1 for 3 cycles while key1 toggles -> led0=0, cnt=0, stable=1 throughout.
REQ-025 Glitch: key1=0 for 2 cycles, then 1 -> led0 stays 0, and cnt returns to 0.
REQ-026 Clean press: key1=0 for 30 cycles -> led0 goes 0->1 at exactly edge 11 and does not toggle again; release for 30 cycles -> led0 stays 1; second identical press -> led0 1->0.
REQ-027 Bounce: key1 low 5 cycles, high 1 cycle, low 20 cycles -> a single toggle, occurring 11 edges after the final falling sample.
REQ-028 Reset mid-count: key1 low for 6 cycles, rst_n=1 for 1 cycle, key1 kept low -> led0=0 after reset, then toggles to 1 at edge 11 after the first post-reset edge.
REQ-029 Release bounce: while stable=0, key1 high 4 cycles, low 1 cycle, repeated -> stable stays 0 and led0 is unchanged.

Source files
------------

// File: rtl/key_pkg.sv
// Shared constants and types for the push-button debounce slice.
// Holds the default debounce window and the counter width.
package key_pkg;

   localparam int CNT_W = 20;

   typedef logic [CNT_W-1:0] cnt_t;

   // 20 ms at 50 MHz
   localparam cnt_t CNT_MAX_DEF = 20'd1_000_000;

endpackage

// File: rtl/key_debounce.sv
// Synchronizes the raw active-low key and debounces it.
// Emits the accepted level and a press pulse ahead of the commit edge.
module key_debounce
   import key_pkg::*;
#(
   parameter cnt_t CNT_MAX = CNT_MAX_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key1,
   output logic stable,
   output logic press
);

   localparam cnt_t LAST = CNT_MAX - cnt_t'(1);

   logic s1;
   logic s2;
   cnt_t cnt;

   // two-flop synchronizer for the asynchronous key input
   always_ff @(posedge clk) begin
      if (rst_n) begin
         s1 <= 1'b1;
         s2 <= 1'b1;
      end else begin
         s1 <= key1;
         s2 <= s1;
      end
   end

   // window counter: any agreement restarts it, full window commits
   always_ff @(posedge clk) begin
      if (rst_n) begin
         stable <= 1'b1;
         cnt    <= '0;
      end else if (s2 == stable) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         stable <= s2;
         cnt    <= '0;
      end else begin
         cnt <= cnt + cnt_t'(1);
      end
   end

   // high in the cycle whose closing edge commits stable 1->0
   assign press = (s2 != stable) && (cnt == LAST) && !s2;

endmodule

// File: rtl/key.sv
// Push-button LED toggle: one toggle per debounced press.
// Debouncing lives in key_debounce; this level owns the LED register.
module key
   import key_pkg::*;
#(
   parameter cnt_t CNT_MAX = CNT_MAX_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key1,
   output logic led0
);

   logic stable;
   logic press;

   key_debounce #(
      .CNT_MAX (CNT_MAX)
   ) u_deb (
      .clk    (clk),
      .rst_n  (rst_n),
      .key1   (key1),
      .stable (stable),
      .press  (press)
   );

   // toggle the LED on the edge where a press is accepted from release
   always_ff @(posedge clk) begin
      if (rst_n) begin
         led0 <= 1'b0;
      end else if (press && stable) begin
         led0 <= ~led0;
      end
   end

endmodule

// File: tb/tb_key.sv
// Randomized scoreboard bench for the key debounce / LED toggle.
// Reference model works on run lengths of the 2-cycle-delayed key.
module tb_key;

   localparam int CM = 10;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic key1 = 1'b1;
   logic led0;

   key #(
      .CNT_MAX (20'd10)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .key1  (key1),
      .led0  (led0)
   );

   always #10 clk = ~clk;

   typedef struct {
      logic led;
      logic stb;
   } exp_t;

   exp_t q[$];

   int n_chk = 0;
   int n_fail = 0;

   // model state: last two key samples, accepted level, LED, run length
   bit h0 = 1'b1;
   bit h1 = 1'b1;
   bit m_stb = 1'b1;
   bit m_led = 1'b0;
   int run = 0;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endfunction

   // expected state after one rising edge with inputs k / r
   task automatic edge_model(bit k, bit r);
      bit v;
      if (r) begin
         h0    = 1'b1;
         h1    = 1'b1;
         m_stb = 1'b1;
         m_led = 1'b0;
         run   = 0;
      end else begin
         v = h1;
         if (v != m_stb) begin
            run++;
            if (run == CM) begin
               m_stb = v;
               run   = 0;
               if (!v) m_led = ~m_led;
            end
         end else begin
            run = 0;
         end
         h1 = h0;
         h0 = k;
      end
      q.push_back('{led: m_led, stb: m_stb});
   endtask

   task automatic step(bit k, bit r = 1'b0);
      @(negedge clk);
      key1  = k;
      rst_n = r;
      edge_model(k, r);
   endtask

   task automatic hold(bit k, int n, bit r = 1'b0);
      for (int i = 0; i < n; i++) step(k, r);
   endtask

   // monitor: compare DUT against the oldest expectation each cycle
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("led0", 32'(led0), 32'(e.led));
            chk("stable", 32'(dut.u_deb.stable), 32'(e.stb));
         end
      end
   end

   initial begin
      // reset held while key toggles
      for (int i = 0; i < 3; i++) begin
         step(i[0], 1'b1);
         @(posedge clk);
         #2;
         chk("rst_cnt", 32'(dut.u_deb.cnt), 32'd0);
      end
      hold(1'b1, 4);

      // short glitch
      hold(1'b0, 2);
      hold(1'b1, 6);
      @(posedge clk);
      #2;
      chk("glitch_cnt", 32'(dut.u_deb.cnt), 32'd0);

      // clean press, release, second press, release
      hold(1'b0, 30);
      hold(1'b1, 30);
      hold(1'b0, 30);
      hold(1'b1, 30);

      // press bounce
      hold(1'b0, 5);
      hold(1'b1, 1);
      hold(1'b0, 20);
      hold(1'b1, 30);

      // reset in the middle of a count
      hold(1'b0, 6);
      step(1'b0, 1'b1);
      hold(1'b0, 20);
      hold(1'b1, 30);

      // release bounce while held
      hold(1'b0, 20);
      for (int i = 0; i < 6; i++) begin
         hold(1'b1, 4);
         hold(1'b0, 1);
      end
      hold(1'b1, 30);

      // random key activity with occasional resets
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 39) == 0)
            hold(1'(key1), 1, 1'b1);
         hold(1'($urandom % 2), int'($urandom_range(1, 25)));
      end
      hold(1'b1, 30);

      repeat (3) @(posedge clk);
      #2;
      chk("drain", 32'(q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
